// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan sequencer.
// Optional parity output is enabled with MUX_SCAN_PARITY_EN.
package mux_scan_pkg;

   localparam int SEL_W  = 4;
   localparam int NUM_CH = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage

// File: rtl/mux_scan_settle_ctr.sv
// Loadable up/down counter with clear and terminal-count flag.
// Times the settle wait after each select change.
module mux_scan_settle_ctr
   import mux_scan_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic         up,
   input  logic [W-1:0] term,
   output logic         tc
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en) begin
         cnt <= up ? cnt + 1'b1 : cnt - 1'b1;
      end
   end

   assign tc = (cnt == term);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps a 16:1 mux select through every channel and packs the samples.
// Define MUX_SCAN_PARITY_EN to add a parity output over each new word.
module mux_scan_sequencer
   import mux_scan_pkg::*;
#(
   parameter int SEL_W      = mux_scan_pkg::SEL_W,
   parameter int SETTLE_CYC = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  mux_out,
   output logic [SEL_W-1:0]      select,
   output logic                  busy,
   output logic                  done,
   output logic [2**SEL_W-1:0]   word
`ifdef MUX_SCAN_PARITY_EN
   ,
   output logic                  parity
`endif
);

   localparam int NCH = 2**SEL_W;
   localparam int CW  = 4;

   state_t         state;
   state_t         nxt;
   logic [NCH-1:0] acc;
   logic [NCH-1:0] merged;
   logic           ctr_clr;
   logic           ctr_en;
   logic           tc;

   mux_scan_settle_ctr #(
      .W(CW)
   ) u_settle (
      .clk      (clk),
      .rst      (rst),
      .clr      (ctr_clr),
      .load     (1'b0),
      .load_val ('0),
      .en       (ctr_en),
      .up       (1'b1),
      .term     (CW'(SETTLE_CYC - 1)),
      .tc       (tc)
   );

   always_comb begin
      nxt     = state;
      ctr_clr = 1'b0;
      ctr_en  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               nxt     = SETTLE;
               ctr_clr = 1'b1;
            end
         end
         SETTLE: begin
            ctr_en = 1'b1;
            if (tc) nxt = SAMPLE;
         end
         SAMPLE: begin
            ctr_clr = 1'b1;
            nxt     = (&select) ? DONE : SETTLE;
         end
         DONE: nxt = IDLE;
      endcase
   end

   // Last channel's sample goes straight into word so done sees it.
   always_comb begin
      merged         = acc;
      merged[select] = mux_out;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         select <= '0;
         acc    <= '0;
         word   <= '0;
`ifdef MUX_SCAN_PARITY_EN
         parity <= 1'b0;
`endif
      end else begin
         state <= nxt;
         if (state == SAMPLE) begin
            acc[select] <= mux_out;
            if (&select) begin
               word <= merged;
`ifdef MUX_SCAN_PARITY_EN
               parity <= ^merged;
`endif
            end else begin
               select <= select + 1'b1;
            end
         end
         if (state == DONE) select <= '0;
      end
   end

   assign busy = (state == SETTLE) || (state == SAMPLE);
   assign done = (state == DONE);

endmodule
